// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier: unpack/classify, mantissa product, normalise/round/export.
// Subnormal inputs are flushed to zero and tiny results flush to signed zero.
module fp_mul_pipe #(
  parameter int  EXP_W = 8,
  parameter int  MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   out_flags
);

  localparam int EW2 = EXP_W + 2;
  localparam int MW1 = MAN_W + 1;
  localparam int PW  = 2 * MW1;

  localparam logic        [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EZERO = '0;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [MAN_W-1:0] MAN_ONES = '1;
  localparam logic [MAN_W-1:0] MAN_ZERO = '0;

  typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} cls_t;

  function automatic cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    cls_t c;
    if (e == EXP_ZERO)      c = CL_ZERO;
    else if (e != EXP_ONES) c = CL_NORM;
    else if (m == MAN_ZERO) c = CL_INF;
    else                    c = CL_NAN;
    return c;
  endfunction

  // Handshake: a stage register moves only when the output is not stalled
  // (out_valid & ~out_ready); in_ready is the inverse of that stall, so every
  // stage including bubbles advances together and a held result never changes.
  logic w_stall;
  logic w_adv;
  assign w_stall  = out_valid & ~out_ready;
  assign w_adv    = ~w_stall;
  assign in_ready = ~w_stall;

  // Stage 1: unpack and classify
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_man, w_b_man;
  logic [EW2-1:0]   w_e_sum;
  assign w_a_exp = in_a[W-2:MAN_W];
  assign w_b_exp = in_b[W-2:MAN_W];
  assign w_a_man = in_a[MAN_W-1:0];
  assign w_b_man = in_b[MAN_W-1:0];
  assign w_e_sum = {2'b00, w_a_exp} + {2'b00, w_b_exp} - BIAS;

  logic                  r1_valid, r2_valid, r3_valid;
  logic                  r1_sign, r2_sign;
  cls_t                  r1_cls_a, r1_cls_b, r2_cls_a, r2_cls_b;
  logic        [MW1-1:0] r1_man_a, r1_man_b;
  logic signed [EW2-1:0] r1_e, r2_e;
  logic        [PW-1:0]  r2_prod;
  logic        [W-1:0]   r3_result;
  logic        [3:0]     r3_flags;

  // Stage 3: normalise, round to nearest even, range check, specials
  logic                  w_shift, w_g, w_r, w_s, w_up, w_carry, w_inexact;
  logic        [MAN_W:0] w_mant;
  logic      [MAN_W+1:0] w_mant_r;
  logic    [MAN_W-1:0]   w_frac;
  logic signed [EW2-1:0] w_e_fin;
  logic                  w_any_nan, w_any_inf, w_any_zero, w_zero_inf;
  logic        [W-1:0]   w_res;
  logic        [3:0]     w_flags;

  always_comb begin
    w_shift = r2_prod[PW-1];
    w_mant  = r2_prod[PW-2:MAN_W];
    w_g     = r2_prod[MAN_W-1];
    w_r     = r2_prod[MAN_W-2];
    w_s     = |r2_prod[MAN_W-3:0];
    if (w_shift) begin
      w_mant = r2_prod[PW-1:MAN_W+1];
      w_g    = r2_prod[MAN_W];
      w_r    = r2_prod[MAN_W-1];
      w_s    = |r2_prod[MAN_W-2:0];
    end
    w_up      = w_g & (w_r | w_s | w_mant[0]);
    w_inexact = w_g | w_r | w_s;
    w_mant_r  = {1'b0, w_mant} + {{MW1{1'b0}}, w_up};
    w_carry   = w_mant_r[MAN_W+1];
    // A carry leaves 10.00..0, whose stored fraction is all zeros
    w_frac    = w_carry ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
    w_e_fin   = r2_e + EW2'(w_shift) + EW2'(w_carry);

    w_zero_inf = ((r2_cls_a == CL_ZERO) && (r2_cls_b == CL_INF)) ||
                 ((r2_cls_a == CL_INF)  && (r2_cls_b == CL_ZERO));
    w_any_nan  = (r2_cls_a == CL_NAN) || (r2_cls_b == CL_NAN) || w_zero_inf;
    w_any_inf  = (r2_cls_a == CL_INF) || (r2_cls_b == CL_INF);
    w_any_zero = (r2_cls_a == CL_ZERO) || (r2_cls_b == CL_ZERO);

    w_res   = {r2_sign, w_e_fin[EXP_W-1:0], w_frac};
    w_flags = {3'b000, w_inexact};
    if (w_any_nan) begin
      w_res   = {1'b0, EXP_ONES, MAN_ONES};
      w_flags = {w_zero_inf, 3'b000};
    end else if (w_any_inf) begin
      w_res   = {r2_sign, EXP_ONES, MAN_ZERO};
      w_flags = 4'b0000;
    end else if (w_any_zero) begin
      w_res   = {r2_sign, EXP_ZERO, MAN_ZERO};
      w_flags = 4'b0000;
    end else if (w_e_fin >= EMAX) begin
      w_res   = {r2_sign, EXP_ONES, MAN_ZERO};
      w_flags = 4'b0101;
    end else if (w_e_fin <= EZERO) begin
      w_res   = {r2_sign, EXP_ZERO, MAN_ZERO};
      w_flags = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid  <= 1'b0;
      r1_sign   <= 1'b0;
      r1_cls_a  <= CL_ZERO;
      r1_cls_b  <= CL_ZERO;
      r1_man_a  <= '0;
      r1_man_b  <= '0;
      r1_e      <= '0;
      r2_valid  <= 1'b0;
      r2_sign   <= 1'b0;
      r2_cls_a  <= CL_ZERO;
      r2_cls_b  <= CL_ZERO;
      r2_prod   <= '0;
      r2_e      <= '0;
      r3_valid  <= 1'b0;
      r3_result <= '0;
      r3_flags  <= '0;
    end else if (w_adv) begin
      r1_valid  <= in_valid;
      r1_sign   <= in_a[W-1] ^ in_b[W-1];
      r1_cls_a  <= classify(w_a_exp, w_a_man);
      r1_cls_b  <= classify(w_b_exp, w_b_man);
      r1_man_a  <= {1'b1, w_a_man};
      r1_man_b  <= {1'b1, w_b_man};
      r1_e      <= w_e_sum;
      r2_valid  <= r1_valid;
      r2_sign   <= r1_sign;
      r2_cls_a  <= r1_cls_a;
      r2_cls_b  <= r1_cls_b;
      r2_prod   <= {{MW1{1'b0}}, r1_man_a} * {{MW1{1'b0}}, r1_man_b};
      r2_e      <= r1_e;
      r3_valid  <= r2_valid;
      r3_result <= w_res;
      r3_flags  <= w_flags;
    end
  end

  assign out_valid = r3_valid;
  assign result    = r3_result;
  assign out_flags = r3_flags;

endmodule
